// File: rtl/i2c_cmd_arbiter_if.sv
// Command bundle between the requesters, the arbiter and the I2C write engine.
// master: arbiter side (drives grant/done/err/start/data/busy); slave: environment side.
interface i2c_cmd_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]    i_req;
   logic [24*NUM_REQ-1:0] i_req_data;
   logic [NUM_REQ-1:0]    o_grant;
   logic [NUM_REQ-1:0]    o_done;
   logic [NUM_REQ-1:0]    o_err;
   logic                  o_start;
   logic [23:0]           o_data;
   logic                  i_finished;
   logic                  o_busy;

   modport master (
      input  i_req, i_req_data, i_finished,
      output o_grant, o_done, o_err, o_start, o_data, o_busy
   );

   modport slave (
      output i_req, i_req_data, i_finished,
      input  o_grant, o_done, o_err, o_start, o_data, o_busy
   );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one 24-bit I2C write engine among NUM_REQ sources.
// Ports: i_clk, i_rst_n (async, active-low), bus (master modport: requests in, grant/done/err/start/data/busy out).
module i2c_cmd_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 1023
) (
   input logic             i_clk,
   input logic             i_rst_n,
   i2c_cmd_arbiter_if.master bus
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] P_LAST = PW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      gidx_q, gidx_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [NUM_REQ-1:0] err_q, err_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic [23:0]        data_q, data_d;
   logic [TW-1:0]      timer_q, timer_d;

   logic               sel_found;
   logic [PW-1:0]      sel_idx;

   // Rotating scan: first requester at or above the pointer, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!sel_found && bus.i_req[(int'(ptr_q) + i) % NUM_REQ]) begin
            sel_found = 1'b1;
            sel_idx   = PW'((int'(ptr_q) + i) % NUM_REQ);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      data_d  = data_q;
      timer_d = timer_q;
      done_d  = '0;
      err_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               state_d = S_LAUNCH;
               gidx_d  = sel_idx;
               grant_d = NUM_REQ'(1) << sel_idx;
               data_d  = bus.i_req_data[24*sel_idx +: 24];
            end
         end
         S_LAUNCH: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A finish on the last timer cycle beats the timeout.
            if (bus.i_finished) begin
               state_d = S_DONE;
               done_d  = grant_q;
            end else if (timer_q == T_LAST) begin
               state_d = S_DONE;
               done_d  = grant_q;
               err_d   = grant_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DONE: begin
            ptr_d   = (gidx_q == P_LAST) ? '0 : gidx_q + 1'b1;
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      start_d = (state_d == S_LAUNCH);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= 24'h000000;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         err_q   <= err_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         timer_q <= timer_d;
      end
   end

   assign bus.o_grant = grant_q;
   assign bus.o_done  = done_q;
   assign bus.o_err   = err_q;
   assign bus.o_start = start_q;
   assign bus.o_busy  = busy_q;
   assign bus.o_data  = data_q;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed plus randomized bench for i2c_cmd_arbiter against a transaction-level model.
// dut_a uses the default timeout, dut_b uses TIMEOUT=16.
module tb_i2c_cmd_arbiter;
   localparam int N = 3;
   localparam int T = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   i2c_cmd_arbiter_if #(.NUM_REQ(N)) aif ();
   i2c_cmd_arbiter_if #(.NUM_REQ(N)) bif ();

   i2c_cmd_arbiter #(.NUM_REQ(N)) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (aif.master)
   );

   i2c_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bif.master)
   );

   int errors = 0;
   int checks = 0;
   int mptr = 0;
   int gout;
   bit fixw = 1'b0;
   logic [2:0] held = '0;
   logic [23:0] word [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [2:0] r, input int p);
      for (int i = 0; i < N; i++)
         if (r[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   task automatic drive_b();
      bif.i_req = held;
      bif.i_req_data = {word[2], word[1], word[0]};
   endtask

   // Called on an IDLE-cycle negedge; returns on the following IDLE negedge.
   // d: WAIT cycle (1-based) in which the engine pulses i_finished.
   task automatic txn(input logic [2:0] add, input int d, input bit lfin,
                      input bit drop, output int g);
      int cexp;
      int cgot;
      logic [23:0] w;
      for (int i = 0; i < N; i++)
         if (add[i] && !held[i] && !fixw) word[i] = 24'($urandom);
      held |= add;
      drive_b();
      g = pick(held, mptr);
      w = word[g];
      @(negedge clk);
      chk("start", 32'(bif.o_start), 1);
      chk("grant", 32'(bif.o_grant), 32'(1 << g));
      chk("data", 32'(bif.o_data), 32'(w));
      if (lfin) bif.i_finished = 1'b1;
      cexp = ((d < T) ? d : T) + 1;
      cgot = -1;
      for (int c = 1; c <= T + 3 && cgot < 0; c++) begin
         @(negedge clk);
         if (bif.o_done != '0) cgot = c;
         else begin
            bif.i_finished = (c == d);
            if (drop && c == 1) begin
               held[g] = 1'b0;
               drive_b();
            end
         end
      end
      chk("done_cycle", 32'(cgot), 32'(cexp));
      chk("done", 32'(bif.o_done), 32'(1 << g));
      chk("err", 32'(bif.o_err), (d > T) ? 32'(1 << g) : 32'd0);
      chk("grant_in_done", 32'(bif.o_grant), 32'(1 << g));
      bif.i_finished = 1'b0;
      held[g] = 1'b0;
      drive_b();
      mptr = (g + 1) % N;
      @(negedge clk);
      chk("idle", 32'({bif.o_busy, bif.o_grant, bif.o_done, bif.o_start}), 0);
      chk("data_held", 32'(bif.o_data), 32'(w));
   endtask

   initial begin
      int cg;
      aif.i_req = '0;
      aif.i_req_data = '0;
      aif.i_finished = 1'b0;
      bif.i_finished = 1'b0;
      word[0] = 24'h340815;
      word[1] = 24'h340A00;
      word[2] = 24'h340C00;
      held = 3'b111;
      fixw = 1'b1;
      drive_b();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_a", 32'({aif.o_busy, aif.o_start, aif.o_grant, aif.o_done, aif.o_err}), 0);
      chk("rst_a_data", 32'(aif.o_data), 0);
      chk("rst_b", 32'({bif.o_busy, bif.o_start, bif.o_grant, bif.o_done, bif.o_err}), 0);
      chk("rst_b_data", 32'(bif.o_data), 0);

      // Round-robin with all three held, each re-raised after its done.
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         txn(3'b111, 3 + i, 1'b0, 1'b0, gout);
         chk("rr_order", 32'(gout), 32'(i % 3));
      end
      fixw = 1'b0;

      // Pointer wrap after requester 2.
      held = '0;
      drive_b();
      txn(3'b101, 8, 1'b0, 1'b0, gout);
      chk("wrap_first", 32'(gout), 0);
      txn(3'b000, 2, 1'b0, 1'b0, gout);
      chk("wrap_second", 32'(gout), 2);

      // Timeout, finish on last WAIT cycle, finish in LAUNCH, drop after grant.
      txn(3'b010, 100, 1'b0, 1'b0, gout);
      txn(3'b001, T, 1'b0, 1'b0, gout);
      txn(3'b100, 100, 1'b1, 1'b0, gout);
      txn(3'b010, 3, 1'b1, 1'b1, gout);

      // Randomized traffic.
      for (int i = 0; i < 20; i++) begin
         logic [2:0] add;
         add = 3'($urandom_range(0, 7));
         if ((held | add) == '0) add = 3'b001;
         txn(add, int'($urandom_range(1, T + 3)), 1'($urandom),
             1'($urandom), gout);
      end

      // Single long transaction on the default-timeout instance.
      aif.i_req_data = {24'h0, 24'h0, 24'h341E00};
      aif.i_req = 3'b001;
      @(negedge clk);
      chk("a_start", 32'(aif.o_start), 1);
      chk("a_data", 32'(aif.o_data), 32'h341E00);
      cg = -1;
      for (int c = 1; c <= 45 && cg < 0; c++) begin
         @(negedge clk);
         if (aif.o_done != '0) cg = c;
         else aif.i_finished = (c == 40);
      end
      chk("a_done_cycle", 32'(cg), 41);
      chk("a_done", 32'(aif.o_done), 1);
      chk("a_err", 32'(aif.o_err), 0);
      aif.i_finished = 1'b0;
      aif.i_req = '0;
      @(negedge clk);
      chk("a_idle", 32'({aif.o_busy, aif.o_grant}), 0);

      // Reset in the middle of WAIT.
      held = 3'b010;
      drive_b();
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", 32'(bif.o_busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid", 32'({bif.o_busy, bif.o_start, bif.o_grant, bif.o_done, bif.o_err}), 0);
      chk("rst_mid_data", 32'(bif.o_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      mptr = 0;
      txn(3'b101, 4, 1'b0, 1'b0, gout);
      chk("rst_prio", 32'(gout), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Round-robin arbiter and sequencer that shares one 24-bit I2C write engine between several command sources, such as the power-up codec initializer and runtime volume/format updates. It accepts a 24-bit command word (device address, register, data) from each requester, launches exactly one engine transaction at a time, and returns a per-requester completion or timeout pulse. It sits between the command sources and the I2C write engine. The engine's `o_sclk`/`o_sdat`/`o_oen` pins bypass this block.

## Interface
- `NUM_REQ`, default 3: number of requesters, range 2..8.
- `TIMEOUT`, default 1023: maximum number of WAIT cycles before a transaction is abandoned, range 1..65535.

- `i_clk`, in, 1: single clock; all state is updated on its rising edge.
- `i_rst_n`, in, 1: reset, asynchronous and active-low.
- `i_req`, in, NUM_REQ: request k is held high until the cycle after `o_done[k]`.
- `i_req_data`, in, 24*NUM_REQ: requester k's command occupies bits [24k+23:24k]. It must be stable while `i_req[k]` is high.
- `o_grant`, out, NUM_REQ: one-hot, and high for the granted requester from LAUNCH through DONE inclusive.
- `o_done`, out, NUM_REQ: one-cycle completion pulse to the granted requester.
- `o_err`, out, NUM_REQ: one-cycle pulse coincident with `o_done`, asserted only on timeout.
- `o_start`, out, 1: one-cycle launch pulse to the engine.
- `o_data`, out, 24: command word to the engine. It is held from LAUNCH until the next grant.
- `i_finished`, in, 1: one-cycle completion pulse from the engine.
- `o_busy`, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE. All outputs are registered.
- Reset values:
  - State is IDLE.
  - `o_grant`, `o_done`, `o_err`, `o_start` and `o_busy` are 0.
  - `o_data` is 24'h000000.
  - The round-robin pointer is 0, so requester 0 has the highest priority.
  - The timer is 0.
- IDLE:
  - If any `i_req` bit is high, select the first set bit searching upward from the pointer and wrapping modulo NUM_REQ.
  - Latch that requester's word into `o_data`, set its `o_grant` bit, and go to LAUNCH.
  - If no request is present, remain in IDLE.
- LAUNCH:
  - `o_start` is 1 for exactly this cycle.
  - Clear the timer and go to WAIT.
  - `i_finished` is ignored in this state.
- WAIT:
  - If `i_finished`=1, go to DONE with err=0.
  - Otherwise, if timer == TIMEOUT-1, go to DONE with err=1.
  - Otherwise, increment the timer.
  - If `i_finished` and the timeout occur in the same cycle, `i_finished` wins and err=0.
- DONE:
  - Pulse `o_done[g]`, and `o_err[g]` if the err flag is set, for one cycle.
  - Set the pointer to (g+1) mod NUM_REQ.
  - Return to IDLE, with `o_grant` clearing at that edge.
- Boundary rules:
  - `i_finished` outside WAIT is ignored.
  - A requester dropping `i_req` after the grant does not abort the transaction; `o_done` is still pulsed.
  - Requests that arrive while busy are held by their sources and are not queued internally.
  - Only the pointer scan wraps. The timer width is ceil(log2(TIMEOUT+1)) and the timer never wraps.
  - An `i_rst_n` assertion at any point forces all reset values immediately, including mid-WAIT. A partially sent I2C frame is the engine's responsibility.

## Timing
- Request to start: `i_req` sampled high at edge n (IDLE) gives `o_start`=1 and `o_grant` set in cycle n+1.
- Finish to done: `i_finished` high at edge m (WAIT) gives `o_done` in cycle m+1, and IDLE from edge m+2.
- The earliest next grant is sampled at edge m+2 (IDLE), so the next `o_start` comes in cycle m+3.
- Back-to-back overhead: 3 cycles between engine completion and the next launch.
- Timeout: WAIT lasts at most TIMEOUT cycles, and `o_done`/`o_err` appear in the cycle after the last WAIT cycle.
- `o_data` is stable for the entire interval in which the engine may sample it.

## Test plan
1. **Single request.** Raise `i_req`=3'b001 with word 24'h341E00, and have the engine return `i_finished` 40 cycles after `o_start`. Required: `o_start` one cycle after the request, `o_data`=24'h341E00, `o_done`=3'b001 one cycle after `i_finished`, `o_err`=0.
2. **Simultaneous requests and round-robin order.** Hold `i_req`=3'b111 continuously from reset, re-raising each requester right after its done. Required grant order: 0,1,2,0,1,2. Each `o_data` matches its source word: 24'h340815, 24'h340A00, 24'h340C00.
3. **Pointer wrap.** Complete a request from requester 2, then raise `i_req`=3'b101. Required: requester 0 is granted first.
4. **Timeout.** Use TIMEOUT=16 and never pulse `i_finished`. Required: exactly 16 WAIT cycles, then `o_done`=`o_err`=one-hot of the granted requester, then IDLE.
5. **Finish on the timeout cycle, plus out-of-state finish.** With TIMEOUT=16, pulse `i_finished` in the 16th WAIT cycle. Required: `o_err`=0. Separately, an `i_finished` in LAUNCH is ignored.
6. **Reset mid-operation.** Assert `i_rst_n`=0 during WAIT. Required: all outputs are 0 immediately. After release, requester 0 has priority again.
